// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES round controller: FSM states, round-type
// selector codes, key-length codes and the key-length to round-count mapping.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_INIT  = 3'd2,
        ST_KEY   = 3'd3,
        ST_ROUND = 3'd4,
        ST_FINAL = 3'd5,
        ST_DONE  = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        RS_ARK   = 2'd0,
        RS_FULL  = 2'd1,
        RS_FINAL = 2'd2
    } round_sel_t;

    localparam logic [1:0] KEYLEN_128 = 2'd0;
    localparam logic [1:0] KEYLEN_192 = 2'd1;
    localparam logic [1:0] KEYLEN_256 = 2'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        logic [3:0] nr;
        case (key_len)
            KEYLEN_128: nr = NR_128;
            KEYLEN_192: nr = NR_192;
            KEYLEN_256: nr = NR_256;
            default:    nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Loadable round-key index counter that saturates at end_val and flags the last round.
// The count-down path exists only when AES_ROUND_CTRL_DEC_EN is defined.
module aes_round_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic         down,
    input  logic [W-1:0] end_val,
    output logic [W-1:0] cnt,
    output logic         last
);

    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

`ifndef AES_ROUND_CTRL_DEC_EN
    logic down_unused;
    assign down_unused = down;
`endif

    // Next count: load has priority; a step never moves past the bound.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (step) begin
`ifdef AES_ROUND_CTRL_DEC_EN
            if (down) begin
                if (cnt_q != ZERO) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    cnt_d = cnt_q;
                end
            end else if (cnt_q < end_val) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q;
            end
`else
            if (cnt_q < end_val) begin
                cnt_d = cnt_q + ONE;
            end else begin
                cnt_d = cnt_q;
            end
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == end_val);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer: LOAD, INIT (AddRoundKey), (KEY, ROUND) x (Nr-1), KEY, FINAL, DONE.
// Decryption ordering (descending round index) is built only when AES_ROUND_CTRL_DEC_EN is defined.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int IDX_W       = 4,
    parameter int MAX_KEY_LEN = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic             decrypt,
    input  logic             out_ready,
    output logic             busy,
    output logic             out_valid,
    output logic             err,
    output logic             load_en,
    output logic             key_step_en,
    output logic             state_en,
    output logic [1:0]       round_sel,
    output logic [IDX_W-1:0] round_idx
);

    localparam logic [1:0]       MAX_KL   = 2'(MAX_KEY_LEN);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    ctrl_state_t      state_d, state_q;
    logic [IDX_W-1:0] nr_d, nr_q;
    logic             dir_d, dir_q;
    logic             err_d, err_q;
    logic             busy_d, busy_q;
    logic             out_valid_d, out_valid_q;
    logic             load_en_d, load_en_q;
    logic             key_step_en_d, key_step_en_q;
    logic             state_en_d, state_en_q;
    round_sel_t       round_sel_d, round_sel_q;

    logic             key_ok_s;
    logic [IDX_W-1:0] nr_new_s;
    logic             dir_new_s;
    logic             cnt_load_s;
    logic             cnt_step_s;
    logic [IDX_W-1:0] cnt_start_s;
    logic [IDX_W-1:0] cnt_end_s;
    logic [IDX_W-1:0] cnt_s;
    logic             last_s;

    assign key_ok_s = (key_len <= MAX_KL);
    assign nr_new_s = IDX_W'(nr_of(key_len));

`ifdef AES_ROUND_CTRL_DEC_EN
    assign dir_new_s = decrypt;
`else
    logic decrypt_unused;
    assign decrypt_unused = decrypt;
    assign dir_new_s      = 1'b0;
`endif

    // Encryption walks 0 -> Nr, decryption walks Nr -> 0.
    assign cnt_start_s = dir_q ? nr_q : IDX_ZERO;
    assign cnt_end_s   = dir_q ? IDX_ZERO : nr_q;

    aes_round_cnt #(
        .W (IDX_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load_s),
        .load_val (cnt_start_s),
        .step     (cnt_step_s),
        .down     (dir_q),
        .end_val  (cnt_end_s),
        .cnt      (cnt_s),
        .last     (last_s)
    );

    // Next-state logic, block parameter capture and counter control.
    always_comb begin
        state_d    = state_q;
        nr_d       = nr_q;
        dir_d      = dir_q;
        err_d      = 1'b0;
        cnt_load_s = 1'b0;
        cnt_step_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && key_ok_s) begin
                    state_d = ST_LOAD;
                    nr_d    = nr_new_s;
                    dir_d   = dir_new_s;
                end else begin
                    state_d = ST_IDLE;
                    err_d   = start;
                end
            end
            ST_LOAD: begin
                state_d    = ST_INIT;
                cnt_load_s = 1'b1;
            end
            ST_INIT: begin
                state_d    = ST_KEY;
                cnt_step_s = 1'b1;
            end
            ST_KEY: begin
                // The counter already holds the freshly stepped index here.
                if (last_s) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                state_d    = ST_KEY;
                cnt_step_s = 1'b1;
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready && start && key_ok_s) begin
                    state_d = ST_LOAD;
                    nr_d    = nr_new_s;
                    dir_d   = dir_new_s;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                    err_d   = start;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they register in step with it.
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        out_valid_d   = (state_d == ST_DONE);
        load_en_d     = (state_d == ST_LOAD);
        key_step_en_d = (state_d == ST_KEY);
        state_en_d    = (state_d == ST_INIT) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
        case (state_d)
            ST_ROUND: round_sel_d = RS_FULL;
            ST_FINAL: round_sel_d = RS_FINAL;
            default:  round_sel_d = RS_ARK;
        endcase
    end

    // State and captured block parameters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            nr_q    <= IDX_W'(NR_128);
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            dir_q   <= dir_d;
        end
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            load_en_q     <= 1'b0;
            key_step_en_q <= 1'b0;
            state_en_q    <= 1'b0;
            round_sel_q   <= RS_ARK;
        end else begin
            err_q         <= err_d;
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            load_en_q     <= load_en_d;
            key_step_en_q <= key_step_en_d;
            state_en_q    <= state_en_d;
            round_sel_q   <= round_sel_d;
        end
    end

    assign err         = err_q;
    assign busy        = busy_q;
    assign out_valid   = out_valid_q;
    assign load_en     = load_en_q;
    assign key_step_en = key_step_en_q;
    assign state_en    = state_en_q;
    assign round_sel   = round_sel_q;
    assign round_idx   = cnt_s;

endmodule
